pic16f84_cycle_seq: RTL and testbench

Consumer of the Q1–Q4 phase outputs of pic16f84_clock; turns quadrature phases into instruction-cycle (Tcy) sequencing.
Owns program counter and instruction register, runs the two-stage fetch/execute overlap, and inserts forced NOPs on branch/skip.
Checks the incoming phase stream for legality; sits between pic16f84_clock and the execute/ALU block.

---
 rtl/pic16f84_pkg.sv | 42 ++++
 rtl/pic16f84_phase_check.sv | 75 +++++++
 rtl/pic16f84_cycle_seq.sv | 88 ++++++++
 tb/tb_pic16f84_cycle_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic16f84_pkg.sv
// Shared types and constants for the PIC16F84 instruction-cycle sequencer.
// Holds the phase and sequencer-state encodings plus phase helper functions.
package pic16f84_pkg;

  localparam int PC_W_DEF   = 13;
  localparam int INSN_W_DEF = 14;

  localparam logic [INSN_W_DEF-1:0] NOP = '0;

  typedef enum logic [1:0] {
    PH_Q1 = 2'd0,
    PH_Q2 = 2'd1,
    PH_Q3 = 2'd2,
    PH_Q4 = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } seq_state_e;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_Q1:   return PH_Q2;
      PH_Q2:   return PH_Q3;
      PH_Q3:   return PH_Q4;
      default: return PH_Q1;
    endcase
  endfunction

  // One-hot strobe pattern {q4,q3,q2,q1} that a given phase must present.
  function automatic logic [3:0] phase_onehot(input phase_e ph);
    case (ph)
      PH_Q1:   return 4'b0001;
      PH_Q2:   return 4'b0010;
      PH_Q3:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

endpackage

// File: rtl/pic16f84_phase_check.sv
// Phase-stream tracker: locks onto Q1, follows Q1..Q4, flags illegal sequences.
// Emits same-edge Q1/Q4 enables for the PC/IR datapath.
module pic16f84_phase_check
  import pic16f84_pkg::*;
(
  input  logic       clk,
  input  logic       mclr,
  input  logic       q1,
  input  logic       q2,
  input  logic       q3,
  input  logic       q4,
  output logic [1:0] q_phase,
  output logic       phase_err,
  output logic       en_q1,
  output logic       en_q4
);

  seq_state_e state;
  phase_e     ph_q;
  phase_e     exp_ph;
  logic [3:0] qvec;
  logic       qvec_ok;

  assign qvec    = {q4, q3, q2, q1};
  assign exp_ph  = next_phase(ph_q);
  assign qvec_ok = (qvec == phase_onehot(exp_ph));
  assign q_phase = ph_q;

  // Enables act on the very edge that samples the strobe; SYNC's lock edge counts as Q1.
  always_comb begin
    en_q1 = 1'b0;
    en_q4 = 1'b0;
    if (state == ST_SYNC && qvec == 4'b0001) begin
      en_q1 = 1'b1;
    end else if (state == ST_RUN && qvec_ok) begin
      en_q1 = (exp_ph == PH_Q1);
      en_q4 = (exp_ph == PH_Q4);
    end
  end

  always_ff @(posedge clk or negedge mclr) begin
    if (!mclr) begin
      state     <= ST_SYNC;
      ph_q      <= PH_Q1;
      phase_err <= 1'b0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (qvec == 4'b0001) begin
            state <= ST_RUN;
            ph_q  <= PH_Q1;
          end
        end
        ST_RUN: begin
          if (qvec_ok) begin
            ph_q <= exp_ph;
          end else if (qvec == 4'b0000) begin
            state <= ST_SYNC;
          end else begin
            state     <= ST_ERR;
            phase_err <= 1'b1;
          end
        end
        ST_ERR: begin
          phase_err <= 1'b1;
        end
        default: begin
          state     <= ST_ERR;
          phase_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pic16f84_cycle_seq.sv
// Instruction-cycle sequencer: owns PC and IR, overlaps fetch/execute across Tcy,
// and replaces the fetched word with a forced NOP after a taken branch or skip.
module pic16f84_cycle_seq
  import pic16f84_pkg::*;
#(
  parameter int PC_WIDTH     = PC_W_DEF,
  parameter int INSN_WIDTH   = INSN_W_DEF,
  parameter int RESET_VECTOR = 0
) (
  input  logic                  clk,
  input  logic                  mclr,
  input  logic                  q1,
  input  logic                  q2,
  input  logic                  q3,
  input  logic                  q4,
  input  logic [INSN_WIDTH-1:0] insn_data,
  input  logic                  branch_req,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  skip_req,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INSN_WIDTH-1:0] ir,
  output logic                  exec_valid,
  output logic                  flush,
  output logic [15:0]           tcy_count,
  output logic [1:0]            q_phase,
  output logic                  phase_err
);

  logic en_q1;
  logic en_q4;
  logic ir_forced;
  logic inhibit_inc;

  pic16f84_phase_check u_phase_check (
    .clk       (clk),
    .mclr      (mclr),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .q4        (q4),
    .q_phase   (q_phase),
    .phase_err (phase_err),
    .en_q1     (en_q1),
    .en_q4     (en_q4)
  );

  // ir after reset is a forced NOP, so the first Tcy never raises exec_valid.
  always_ff @(posedge clk or negedge mclr) begin
    if (!mclr) begin
      pc          <= PC_WIDTH'(RESET_VECTOR);
      ir          <= INSN_WIDTH'(NOP);
      ir_forced   <= 1'b1;
      inhibit_inc <= 1'b1;
      exec_valid  <= 1'b0;
      flush       <= 1'b0;
      tcy_count   <= '0;
    end else begin
      exec_valid <= 1'b0;
      flush      <= 1'b0;
      if (en_q1) begin
        if (inhibit_inc) begin
          inhibit_inc <= 1'b0;
        end else begin
          pc <= pc + PC_WIDTH'(1);
        end
        exec_valid <= ~ir_forced;
      end
      if (en_q4) begin
        tcy_count <= tcy_count + 16'd1;
        if (branch_req) begin
          pc          <= branch_target;
          ir          <= INSN_WIDTH'(NOP);
          ir_forced   <= 1'b1;
          inhibit_inc <= 1'b1;
          flush       <= 1'b1;
        end else if (skip_req) begin
          ir        <= INSN_WIDTH'(NOP);
          ir_forced <= 1'b1;
          flush     <= 1'b1;
        end else begin
          ir        <= insn_data;
          ir_forced <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pic16f84_cycle_seq.sv
// Scoreboard bench for pic16f84_cycle_seq: a Tcy-level model queues expected
// exec/flush events; a negedge monitor pops and compares them as the DUT emits.
module tb_pic16f84_cycle_seq;

  logic        clk = 1'b0;
  logic        mclr = 1'b0;
  logic        q1 = 1'b0, q2 = 1'b0, q3 = 1'b0, q4 = 1'b0;
  logic [13:0] insn_data = '0;
  logic        branch_req = 1'b0;
  logic [12:0] branch_target = '0;
  logic        skip_req = 1'b0;
  logic [12:0] pc;
  logic [13:0] ir;
  logic        exec_valid, flush;
  logic [15:0] tcy_count;
  logic [1:0]  q_phase;
  logic        phase_err;

  pic16f84_cycle_seq dut (
    .clk(clk), .mclr(mclr), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .insn_data(insn_data), .branch_req(branch_req), .branch_target(branch_target),
    .skip_req(skip_req), .pc(pc), .ir(ir), .exec_valid(exec_valid), .flush(flush),
    .tcy_count(tcy_count), .q_phase(q_phase), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_flush;
    logic [12:0] pc;
    logic [13:0] ir;
    logic [15:0] tcy;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [13:0] mem [0:8191];

  // Model state at instruction-cycle granularity
  logic [12:0] m_pc;
  logic [13:0] m_ir;
  logic        m_forced;
  logic        m_inh;
  logic [15:0] m_tcy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exec_valid || flush) begin
      ev_t e;
      chk("single_event", {31'd0, exec_valid & flush}, 32'd0);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got exec=%0b flush=%0b expected none", exec_valid, flush);
      end else begin
        e = sb.pop_front();
        chk(e.is_flush ? "ev_kind_flush" : "ev_kind_exec", {31'd0, flush}, {31'd0, e.is_flush});
        chk("ev_pc", pc, e.pc);
        chk("ev_ir", ir, e.ir);
        chk("ev_tcy", tcy_count, e.tcy);
      end
    end
  end

  task automatic step(input logic [3:0] qv, input logic br, input logic [12:0] tgt,
                      input logic sk, input logic [13:0] din);
    @(negedge clk);
    {q4, q3, q2, q1} = qv;
    branch_req    = br;
    branch_target = tgt;
    skip_req      = sk;
    insn_data     = din;
    @(posedge clk);
    #1;
  endtask

  task automatic noise_step(input logic [3:0] qv);
    step(qv, 1'($urandom), 13'($urandom), 1'($urandom), 14'($urandom));
  endtask

  task automatic model_reset();
    m_pc = 13'd0; m_ir = 14'd0; m_forced = 1'b1; m_inh = 1'b1; m_tcy = 16'd0;
  endtask

  task automatic do_q1();
    ev_t e;
    if (m_inh) m_inh = 1'b0;
    else       m_pc  = m_pc + 13'd1;
    if (!m_forced) begin
      e.is_flush = 1'b0; e.pc = m_pc; e.ir = m_ir; e.tcy = m_tcy;
      sb.push_back(e);
    end
    noise_step(4'b0001);
    chk("q1_pc", pc, m_pc);
    chk("q1_phase", q_phase, 2'd0);
  endtask

  task automatic do_q4(input logic br, input logic [12:0] tgt, input logic sk);
    ev_t e;
    logic [13:0] din;
    din = mem[m_pc];
    m_tcy = m_tcy + 16'd1;
    if (br) begin
      m_pc = tgt; m_ir = 14'd0; m_forced = 1'b1; m_inh = 1'b1;
    end else if (sk) begin
      m_ir = 14'd0; m_forced = 1'b1;
    end else begin
      m_ir = din; m_forced = 1'b0;
    end
    if (br || sk) begin
      e.is_flush = 1'b1; e.pc = m_pc; e.ir = m_ir; e.tcy = m_tcy;
      sb.push_back(e);
    end
    step(4'b1000, br, tgt, sk, din);
    chk("q4_phase", q_phase, 2'd3);
  endtask

  task automatic run_tcy(input logic br, input logic [12:0] tgt, input logic sk);
    do_q1();
    noise_step(4'b0010);
    noise_step(4'b0100);
    chk("q3_phase", q_phase, 2'd2);
    do_q4(br, tgt, sk);
  endtask

  task automatic sync_junk(input int n);
    logic [3:0] junk [7];
    junk = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1111, 4'b1100};
    for (int i = 0; i < n; i++) noise_step(junk[$urandom_range(0, 6)]);
  endtask

  task automatic pulse_mclr();
    @(negedge clk);
    mclr = 1'b0;
    #2;
    chk("rst_pc", pc, 13'd0);
    chk("rst_ir", ir, 14'd0);
    chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_tcy", tcy_count, 16'd0);
    chk("rst_q_phase", q_phase, 2'd0);
    chk("rst_phase_err", {31'd0, phase_err}, 32'd0);
    @(negedge clk);
    mclr = 1'b1;
    model_reset();
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 14'($urandom);
    mem[0] = 14'h3001; mem[1] = 14'h3002; mem[2] = 14'h3003;
    mem[5] = 14'h2A55;
    model_reset();
    repeat (3) @(negedge clk);
    pulse_mclr();

    // Junk strobes in SYNC must not touch pc/ir
    sync_junk(6);
    chk("sync_pc", pc, 13'd0);
    chk("sync_tcy", tcy_count, 16'd0);

    // Straight-line fetch; third Tcy takes a branch to 0x005
    run_tcy(1'b0, 13'd0, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);
    chk("tcy_after2", tcy_count, 16'd2);
    chk("ir_after2", ir, 14'h3002);
    do_q1();
    chk("pc_third", pc, 13'd2);
    noise_step(4'b0010);
    noise_step(4'b0100);
    do_q4(1'b1, 13'h005, 1'b0);
    chk("tcy_after3", tcy_count, 16'd3);
    run_tcy(1'b0, 13'd0, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);

    // Branch and skip together: branch wins; then skip at pc=0x010
    run_tcy(1'b1, 13'h010, 1'b1);
    run_tcy(1'b0, 13'd0, 1'b1);
    run_tcy(1'b0, 13'd0, 1'b0);
    chk("pc_after_skip", pc, 13'h011);

    // PC wrap at all-ones
    run_tcy(1'b1, 13'h1FFE, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);
    chk("pc_wrap", pc, 13'h0000);

    // Clock stop mid-Tcy, then resume from Q1
    do_q1();
    noise_step(4'b0010);
    for (int i = 0; i < 5; i++) begin
      noise_step(4'b0000);
      chk("stop_pc", pc, m_pc);
      chk("stop_phase_err", {31'd0, phase_err}, 32'd0);
    end
    run_tcy(1'b0, 13'd0, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);
    chk("resume_tcy", tcy_count, m_tcy);

    // Randomized run
    for (int t = 0; t < 200; t++) begin
      logic br, sk;
      br = ($urandom_range(0, 7) == 0);
      sk = ($urandom_range(0, 7) == 0);
      run_tcy(br, 13'($urandom), sk);
    end
    chk("rand_tcy", tcy_count, m_tcy);
    chk("rand_ir", ir, m_ir);

    // Out-of-order phase: Q1 then Q3 locks into the error state
    do_q1();
    noise_step(4'b0100);
    chk("err_flag", {31'd0, phase_err}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      noise_step(4'($urandom));
      chk("err_pc", pc, m_pc);
      chk("err_ir", ir, m_ir);
      chk("err_tcy", tcy_count, m_tcy);
      chk("err_sticky", {31'd0, phase_err}, 32'd1);
    end
    pulse_mclr();
    sync_junk(3);
    run_tcy(1'b0, 13'd0, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);
    run_tcy(1'b0, 13'd0, 1'b0);
    chk("recover_pc", pc, 13'd2);
    chk("recover_phase_err", {31'd0, phase_err}, 32'd0);

    // Reset mid-Tcy with a branch request pending: branch is lost
    do_q1();
    step(4'b0010, 1'b1, 13'h0AAA, 1'b0, 14'd0);
    step(4'b0100, 1'b1, 13'h0AAA, 1'b0, 14'd0);
    pulse_mclr();
    run_tcy(1'b0, 13'd0, 1'b0);
    chk("post_rst_pc", pc, 13'd0);

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
